// File: rtl/jt49_mave_sched.sv
// Shared-datapath boxcar averager for CH channels: 2^depth taps, done 2*CH+1 cycles after an accepted cen.
// A cen arriving mid-sequence is dropped; JT49_MAVE_OVF_EN builds the sticky overrun flag, otherwise ovf is tied to 0.
module jt49_mave_sched #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [CH*DW-1:0] din,
  output logic [CH*DW-1:0] dout,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int AW = CW + depth;
  localparam int SW = DW + depth;
  localparam int NW = CH * (2 ** depth);

  typedef enum logic [2:0] {
    S_CLR,
    S_IDLE,
    S_RD,
    S_UPD,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [AW-1:0]        r_clr_cnt;
  logic [CW-1:0]        r_ch;
  logic [depth-1:0]     r_ptr;
  logic [CH*DW-1:0]     r_hold;
  logic signed [SW-1:0] r_sum [CH];
  logic [CH*DW-1:0]     r_dout;
  logic [DW-1:0]        r_mem [NW];
  logic [DW-1:0]        r_rdata;

  logic                 w_last_clr;
  logic                 w_last_ch;
  logic                 w_accept;
  logic                 w_we;
  logic                 w_re;
  logic [AW-1:0]        w_addr;
  logic [AW-1:0]        w_waddr;
  logic [DW-1:0]        w_wdata;
  logic [DW-1:0]        w_din_c;
  logic signed [DW:0]   w_diff;
  logic signed [SW-1:0] w_new_sum;

  assign w_last_clr = (r_clr_cnt == AW'(NW - 1));
  assign w_last_ch  = (r_ch == CW'(CH - 1));
  assign w_addr     = {r_ch, r_ptr};
  assign w_waddr    = (r_state == S_CLR) ? r_clr_cnt : w_addr;
  assign w_din_c    = r_hold[int'(r_ch)*DW +: DW];
  assign w_wdata    = (r_state == S_CLR) ? '0 : w_din_c;
  // Newest sample minus the one falling out of the window; the sum never goes negative.
  assign w_diff     = $signed({1'b0, w_din_c}) - $signed({1'b0, r_rdata});
  assign w_new_sum  = r_sum[r_ch] + SW'(w_diff);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLR;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_CLR: begin
        w_we = 1'b1;
        if (w_last_clr) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (cen) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_re        = 1'b1;
        w_state_nxt = S_UPD;
      end
      S_UPD: begin
        w_we        = 1'b1;
        w_state_nxt = w_last_ch ? S_DONE : S_RD;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_CLR;
    endcase
  end

  // Delay line: write in CLR/UPD and read in RD never collide on the same address.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    if (w_re) r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= '0;
      r_ch      <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_dout    <= '0;
      for (int c = 0; c < CH; c++) r_sum[c] <= '0;
    end else begin
      if (r_state == S_CLR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_accept) begin
        r_hold <= din;
        r_ch   <= '0;
      end
      if (r_state == S_UPD) begin
        r_sum[r_ch]                 <= w_new_sum;
        r_dout[int'(r_ch)*DW +: DW] <= w_new_sum[SW-1:depth];
        if (!w_last_ch) r_ch <= r_ch + 1'b1;
      end
      if (r_state == S_DONE) r_ptr <= r_ptr + 1'b1;
    end
  end

  assign dout = r_dout;
  assign busy = (r_state != S_IDLE);

`ifdef JT49_MAVE_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (cen && (r_state == S_RD || r_state == S_UPD || r_state == S_DONE)) r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jt49_mave_sched.sv
// Bench for jt49_mave_sched (CH=3, DW=8, depth=2): directed plan steps plus random samples against a window-history model.
module tb_jt49_mave_sched;
  localparam int CH    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int W     = 4;
`ifdef JT49_MAVE_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cen = 1'b0;
  logic [CH*DW-1:0] din = '0;
  logic [CH*DW-1:0] dout;
  logic             done;
  logic             busy;
  logic             ovf;

  int n_vec = 0;
  int n_err = 0;
  int hist [CH][$];

  jt49_mave_sched #(.CH(CH), .DW(DW), .depth(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .din  (din),
    .dout (dout),
    .done (done),
    .busy (busy),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: average of the last W accepted samples per channel (zeros before history fills).
  task automatic model_push(input logic [CH*DW-1:0] d);
    for (int c = 0; c < CH; c++) begin
      hist[c].push_back(int'(d[c*DW +: DW]));
      if (hist[c].size() > W) void'(hist[c].pop_front());
    end
  endtask

  function automatic int model_out(input int c);
    int s = 0;
    foreach (hist[c][i]) s += hist[c][i];
    return s / W;
  endfunction

  task automatic model_clear;
    for (int c = 0; c < CH; c++) hist[c].delete();
  endtask

  // Hold rst for ncyc edges, check reset values, then release and time the clear sweep.
  // A cen pulse in the middle of the sweep must be ignored without raising ovf.
  task automatic do_reset(input int ncyc, input string tag);
    int n;
    bit quiet;
    rst = 1'b1;
    cen = 1'b0;
    repeat (ncyc) tick;
    chk({tag, ":rst_dout"}, dout, 0);
    chk({tag, ":rst_done"}, done, 0);
    chk({tag, ":rst_busy"}, busy, 1);
    chk({tag, ":rst_ovf"}, ovf, 0);
    rst = 1'b0;
    n = 0;
    quiet = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      cen = (n == 5);
      din = 24'hA5A5A5;
      tick;
      cen = 1'b0;
      n++;
      if (dout !== '0 || done !== 1'b0) quiet = 1'b0;
    end
    chk({tag, ":clr_len"}, n, CH * W);
    chk({tag, ":clr_quiet"}, quiet, 1);
    chk({tag, ":clr_ovf"}, ovf, 0);
    model_clear();
  endtask

  // One accepted sample. ovr=1..6 pulses an extra cen that many cycles into the sequence,
  // ovr=7 pulses it in the done cycle, 0 means no extra pulse.
  task automatic send(input logic [CH*DW-1:0] d, input int ovr, input string tag);
    int n;
    din = d;
    cen = 1'b1;
    tick;
    cen = 1'b0;
    model_push(d);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == ovr) begin
        cen = 1'b1;
        din = 24'($urandom);
      end
      tick;
      cen = 1'b0;
      if (done === 1'b1) begin
        n = k;
        break;
      end
    end
    chk({tag, ":done_lat"}, n, 2 * CH);
    for (int c = 0; c < CH; c++)
      chk($sformatf("%s:dout%0d", tag, c), dout[c*DW +: DW], model_out(c));
    if (ovr == 7) begin
      cen = 1'b1;
      din = 24'($urandom);
    end
    tick;
    cen = 1'b0;
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_done"}, done, 0);
  endtask

  initial begin
    int ovr;
    do_reset(2, "por");

    for (int i = 0; i < 6; i++) send(24'h000040, 0, $sformatf("step%0d", i));
    chk("step:ch0_final", dout[7:0], 8'h40);
    chk("step:ch12_final", dout[23:8], 16'h0000);

    for (int i = 0; i < 5; i++) send(24'hFF8000, 0, $sformatf("iso%0d", i));
    chk("iso:steady", dout, 24'hFF8000);

    for (int i = 0; i < 4; i++) send(24'h000040, 0, $sformatf("rise%0d", i));
    for (int i = 0; i < 8; i++) send(24'h000000, 0, $sformatf("decay%0d", i));
    chk("decay:final", dout, 24'h000000);

    chk("ovr:pre_ovf", ovf, 0);
    send(24'h123456, 3, "ovr");
    chk("ovr:ovf", ovf, OVF_EXP);

    for (int i = 0; i < 30; i++) begin
      ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      send(24'($urandom), ovr, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) tick;
    end
    chk("rnd:ovf_sticky", ovf, OVF_EXP);

    din = 24'h000040;
    cen = 1'b1;
    tick;
    cen = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    chk("midrst:dout", dout, 0);
    chk("midrst:busy", busy, 1);
    chk("midrst:done", done, 0);
    do_reset(1, "midrst");

    for (int i = 0; i < 6; i++) send(24'h000040, 0, $sformatf("step2_%0d", i));
    chk("step2:ch0_final", dout[7:0], 8'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
